// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader and its UART receiver.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    CHECK,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned RAM_DEPTH         = 16;
  localparam int unsigned ADDR_W            = $clog2(RAM_DEPTH);

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte or framing-error pulse.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s2_q) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_out   = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/program_loader.sv
// Loads a framed 16-byte program from a UART line into the computer's RAM via its
// programming interface, then verifies a mod-256 checksum and releases prog_mode.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned HOLD_CYCLES  = 64,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_mode,
  output logic [3:0] addr,
  output logic [7:0] data,
  output logic       data_oe,
  output logic       done,
  output logic       err
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(RAM_DEPTH - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_out;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .fastClk   (fastClk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_out  (byte_out),
    .frame_err (frame_err)
  );

  state_e              state_q, state_d;
  logic                prog_mode_q, prog_mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                data_oe_q, data_oe_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [7:0]          csum_q, csum_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  always_comb begin
    state_d     = state_q;
    prog_mode_d = prog_mode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    data_oe_d   = data_oe_q;
    done_d      = done_q;
    err_d       = err_q;
    index_d     = index_q;
    csum_d      = csum_q;
    hold_d      = hold_q;
    case (state_q)
      IDLE: begin
        if (byte_valid && byte_out == SYNC_BYTE) begin
          prog_mode_d = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          index_d     = '0;
          csum_d      = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (byte_valid) begin
          data_d    = byte_out;
          addr_d    = index_q;
          data_oe_d = 1'b1;
          csum_d    = csum_q + byte_out;
          hold_d    = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (byte_valid) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (hold_q == HOLD_LAST) begin
          data_oe_d = 1'b0;
          if (index_q == LAST_IDX) begin
            state_d = CHECK;
          end else begin
            index_d = index_q + 1'b1;
            state_d = LOAD;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      CHECK: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (byte_valid) begin
          if (byte_out == csum_q) done_d = 1'b1;
          else                    err_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        prog_mode_d = 1'b0;
        data_oe_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_q     <= IDLE;
      prog_mode_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      index_q     <= '0;
      csum_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      prog_mode_q <= prog_mode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      index_q     <= index_d;
      csum_q      <= csum_d;
      hold_q      <= hold_d;
    end
  end

  assign prog_mode = prog_mode_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign data_oe   = data_oe_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized frames,
// checked against a frame-level model (expected write list, checksum, outcome).
module tb_program_loader;

  localparam int unsigned CPB  = 4;
  localparam int unsigned HOLD = 8;

  logic       fastClk = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       prog_mode, data_oe, done, err;
  logic [3:0] addr;
  logic [7:0] data;

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .HOLD_CYCLES (HOLD),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .fastClk  (fastClk),
    .rst      (rst),
    .rx       (rx),
    .prog_mode(prog_mode),
    .addr     (addr),
    .data     (data),
    .data_oe  (data_oe),
    .done     (done),
    .err      (err)
  );

  always #5 fastClk = ~fastClk;

  int cyc = 0;
  always @(posedge fastClk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         stop_cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_data [16];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fastClk);
      #1;
    end
  endtask

  function automatic logic [7:0] model_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(frame_data[i]);
    return 8'(s % 256);
  endfunction

  // One UART byte, LSB first; a write expectation is queued when the stop bit starts.
  task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit wr, input logic [3:0] a);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = good_stop;
    if (wr) exp_q.push_back('{a: a, d: b, stop_cyc: cyc});
    tick(CPB);
    rx = 1'b1;
  endtask

  // bad_idx: -1 none, 0..15 bad stop bit on that data byte, 16 bad stop on checksum.
  task automatic run_frame(input logic [7:0] chk, input int bad_idx);
    bit exp_done;
    bit stopped;
    int n;
    exp_done = (bad_idx < 0) && (chk == model_sum());
    stopped  = 1'b0;
    send_byte(8'hA5, 1'b1, 1'b0, 4'd0);
    tick(3);
    check("prog_mode_on_sync", prog_mode, 1);
    check("done_clr_on_sync", done, 0);
    check("err_clr_on_sync", err, 0);
    for (int i = 0; i < 16; i++) begin
      if (!stopped) begin
        tick($urandom_range(0, 3));
        if (i == bad_idx) begin
          send_byte(frame_data[i], 1'b0, 1'b0, 4'd0);
          stopped = 1'b1;
        end else begin
          send_byte(frame_data[i], 1'b1, 1'b1, 4'(i));
        end
      end
    end
    if (!stopped) begin
      tick($urandom_range(0, 3));
      send_byte(chk, bad_idx != 16, 1'b0, 4'd0);
    end
    n = 0;
    while (prog_mode && n < 80) begin
      tick(1);
      n++;
    end
    check("frame_end_prog_mode", prog_mode, 0);
    check("frame_end_data_oe", data_oe, 0);
    check("frame_done", done, exp_done);
    check("frame_err", err, !exp_done);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) frame_data[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) frame_data[i] = 8'($urandom);
  endtask

  // Per-cycle compare: every data_oe window must match the next expected write.
  logic prev_oe = 1'b0;
  int   win_len = 0;
  wr_t  cur;
  always @(negedge fastClk) begin
    if (rst) begin
      exp_q.delete();
      prev_oe = 1'b0;
      win_len = 0;
    end else begin
      check("done_err_exclusive", {31'd0, done & err}, 0);
      if (data_oe) begin
        check("oe_implies_prog_mode", prog_mode, 1);
        if (!prev_oe) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with no write pending", addr, data);
            cur = '{a: addr, d: data, stop_cyc: cyc};
          end else begin
            cur = exp_q.pop_front();
            if (cyc < cur.stop_cyc + 1 || cyc > cur.stop_cyc + int'(CPB) + 4) begin
              errors++;
              $display("FAIL write_latency: rose %0d cycles after stop bit, required 1..%0d",
                       cyc - cur.stop_cyc, CPB + 4);
            end
            check("write_addr_data", {20'd0, addr, data}, {20'd0, cur.a, cur.d});
          end
          win_len = 1;
        end else begin
          win_len++;
          check("addr_data_stable", {20'd0, addr, data}, {20'd0, cur.a, cur.d});
        end
      end else if (prev_oe) begin
        check("window_len", win_len, HOLD);
      end
      prev_oe = data_oe;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_prog_mode", prog_mode, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Ramp 0..15 has checksum 0x78.
    fill_ramp();
    run_frame(8'h78, -1);
    check("ramp_good_done", done, 1);
    check("ramp_good_err", err, 0);

    run_frame(8'h77, -1);
    check("ramp_bad_done", done, 0);
    check("ramp_bad_err", err, 1);

    // Non-sync bytes in IDLE are ignored.
    send_byte(8'h3C, 1'b1, 1'b0, 4'd0);
    tick(3);
    check("noise1_prog_mode", prog_mode, 0);
    send_byte(8'h11, 1'b1, 1'b0, 4'd0);
    tick(3);
    check("noise2_prog_mode", prog_mode, 0);
    run_frame(8'h78, -1);
    check("after_noise_done", done, 1);

    // Bad stop bit on the fifth data byte: only addr 0..3 written.
    run_frame(8'h78, 4);
    check("badstop_err", err, 1);
    check("badstop_done", done, 0);

    // Reset while holding addr 7.
    send_byte(8'hA5, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) send_byte(frame_data[i], 1'b1, 1'b1, 4'(i));
    n = 0;
    while (!(data_oe && addr == 4'd7) && n < 20) begin
      tick(1);
      n++;
    end
    check("reached_addr7", {31'd0, data_oe && addr == 4'd7}, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_prog_mode", prog_mode, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_addr", addr, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    fill_random();
    run_frame(model_sum(), -1);

    // Two-cycle low glitch must not swallow the following sync byte.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(4);
    check("glitch_prog_mode", prog_mode, 0);
    fill_random();
    run_frame(model_sum(), -1);

    for (int f = 0; f < 8; f++) begin
      int kind;
      int nn;
      logic [7:0] chk;
      logic [7:0] nb;
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb, 1'b1, 1'b0, 4'd0);
        tick($urandom_range(0, 3));
      end
      fill_random();
      kind = $urandom_range(0, 2);
      chk  = model_sum();
      if (kind == 1) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      run_frame(chk, (kind == 2) ? int'($urandom_range(0, 16)) : -1);
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
